load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes width, checks alignment, runs one memory
// handshake with a bounded wait, and returns an extended load result.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [7:0] WAIT_LAST   = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        illegal, misaligned;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request checks act on the live inputs so the IDLE decision needs no extra cycle.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      illegal = (funct3 > 3'b010);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    if (funct3[1:0] == 2'b01) begin
      misaligned = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      misaligned = (addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = wdata_q;
    if (is_store_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          be_lanes    = 4'b0001 << addr_q[1:0];
          wdata_lanes = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata_q[15:0]}};
        end
        default: begin
          be_lanes    = 4'b1111;
          wdata_lanes = wdata_q;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          cnt_d      = '0;
          if (illegal) begin
            state_d = S_RESP;
            err_d   = ERR_ILLEGAL;
            rdata_d = '0;
          end else if (misaligned) begin
            state_d = S_RESP;
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d = S_RESP;
          err_d   = ERR_OK;
          rdata_d = is_store_q ? '0 : ld_ext;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & is_store_q;
  assign mem_be    = mem_req ? be_lanes : '0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_lanes;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at
// stimulus time and popped by a monitor on every done pulse.
module tb_load_store_unit;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", rdata, mon_e.rdata);
        check("err", {30'b0, err}, {30'b0, mon_e.err});
      end
    end
  end

  function automatic logic m_illegal(input logic st, input logic [2:0] f3);
    if (st) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return a[0];
    if (f3 == 3'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return a[1] ? {{16{d[31]}}, d[31:16]} : {{16{d[15]}}, d[15:0]};
      3'd5:    return a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!st || f3 == 3'd2) return 4'b1111;
    if (f3 == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3 == 3'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (f3 == 3'd1) return {w[15:0], w[15:0]};
    return w;
  endfunction

  // Call at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  // ack_at is the 0-based REQ cycle that gets an ack; values >= MW mean never.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mrd,
                           input int ack_at, input logic hold_start);
    exp_t e;
    int   reqs;
    int   req_seen;
    bit   got;
    if (m_illegal(st, f3)) begin
      e = '{rdata: 32'h0, err: 2'b10}; reqs = 0;
    end else if (m_misal(f3, a)) begin
      e = '{rdata: 32'h0, err: 2'b01}; reqs = 0;
    end else if (ack_at < 0 || ack_at >= int'(MW)) begin
      e = '{rdata: 32'h0, err: 2'b11}; reqs = int'(MW);
    end else begin
      e = '{rdata: (st ? 32'h0 : m_load(f3, a, mrd)), err: 2'b00}; reqs = ack_at + 1;
    end
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    is_store = ~st; funct3 = 3'd7; addr = 32'hFFFF_FFFF; wdata = '0;
    req_seen = 0;
    got = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done) begin
        got = 1;
        check("latency", 32'(cyc), 32'(reqs + 1));
        check("resp_mem_idle", {27'b0, mem_req, mem_we, mem_be}, 32'h0);
        break;
      end
      if (mem_req) begin
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_be", {28'b0, mem_be}, {28'b0, m_be(st, f3, a)});
        check("mem_we", {31'b0, mem_we}, {31'b0, st});
        if (st) check("mem_wdata", mem_wdata, m_wdata(f3, wd));
        mem_ack   = (req_seen == ack_at);
        mem_rdata = mem_ack ? mrd : $urandom();
        req_seen++;
      end else begin
        mem_ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    if (!got) check("done_wait_expired", 32'd0, 32'd1);
    check("req_cycles", 32'(req_seen), 32'(reqs));
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'h0);
    check("busy_after", {31'b0, busy}, 32'h0);
    check("rdata_hold", rdata, e.rdata);
    check("err_hold", {30'b0, err}, {30'b0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {30'b0, err}, 32'h0);
    check("rst_mem_ctl", {27'b0, mem_req, mem_we, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);   // LW
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0);   // LB
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0);   // LBU
    do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FFFF7F, 1, 1'b0);   // LH
    do_access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h5555AAAA, 0, 1'b0); // SH
    do_access(1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 2, 1'b0);   // SB
    do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b0);          // misaligned
    do_access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b0);          // illegal load
    do_access(1'b1, 3'd5, 32'h101, 32'h0, 32'h0, 0, 1'b0);          // illegal beats misaligned
    do_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 99, 1'b0);         // timeout
    do_access(1'b0, 3'd5, 32'h402, 32'h0, 32'hC0018000, 3, 1'b0);   // ack in last cycle
    do_access(1'b1, 3'd2, 32'h500, 32'hCAFEF00D, 32'h0, 2, 1'b1);   // start held while busy

    for (int i = 0; i < 16; i++) begin
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = 32'h1000 + 32'($urandom_range(0, 15));
      do_access(r_st, r_f3, r_a, $urandom(), $urandom(), int'($urandom_range(0, 4)), 1'b0);
    end

    // Reset mid-request aborts the access and a late ack is ignored.
    is_store = 1'b0; funct3 = 3'd2; addr = 32'h600; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_req_up", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_down", {31'b0, mem_req}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    d0 = done_cnt;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("abort_late_ack_busy", {31'b0, busy}, 32'h0);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_rdata", rdata, 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
